// File: rtl/b16fp_vmac.sv
// bfloat16 vector multiply-accumulate: lane products, pipelined adder tree,
// framed accumulation. Includes the combinational b16fpmul/b16fpadd cells.

module b16fpmul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic sa, sb, sy, na, nb, ia, ib, za, zb, g, st, rup;
  logic [7:0] ea, eb, m;
  logic [15:0] p;
  logic [8:0] r;
  logic signed [10:0] e;
  logic unused;

  always_comb begin
    sa = a[15];
    sb = b[15];
    ea = a[14:7];
    eb = b[14:7];
    sy = sa ^ sb;
    za = ea == 8'h00;
    zb = eb == 8'h00;
    na = ea == 8'hff && a[6:0] != 7'h0;
    nb = eb == 8'hff && b[6:0] != 7'h0;
    ia = ea == 8'hff && a[6:0] == 7'h0;
    ib = eb == 8'hff && b[6:0] == 7'h0;
    p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    m = p[15] ? p[15:8] : p[14:7];
    g = p[15] ? p[7] : p[6];
    st = p[15] ? |p[6:0] : |p[5:0];
    rup = g & (st | m[0]);
    r = {1'b0, m} + {8'h00, rup};
    e = $signed({3'b000, ea}) + $signed({3'b000, eb})
      - 11'sd127 + $signed({10'h000, p[15]})
      + $signed({10'h000, r[8]});
    if (na | nb | (ia & zb) | (za & ib))
      y = 16'h7fc0;
    else if (ia | ib)
      y = {sy, 8'hff, 7'h00};
    else if (za | zb)
      y = {sy, 15'h0000};
    else if (e >= 11'sd255)
      y = {sy, 8'hff, 7'h00};
    else if (e <= 11'sd0)
      y = {sy, 15'h0000};
    else
      y = {sy, e[7:0], r[6:0]};
  end

  assign unused = r[7];
endmodule

module b16fpadd (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic na, nb, ia, ib, za, zb, swp, sx, sy2, sub, st, g, rup;
  logic [7:0] ea, eb, ex, ey, d, m;
  logic [6:0] fx, fy;
  logic [18:0] big, sml, sum, norm;
  logic [37:0] wide;
  logic [4:0] p;
  logic [8:0] r;
  logic signed [10:0] e;
  logic unused;

  always_comb begin
    ea = a[14:7];
    eb = b[14:7];
    za = ea == 8'h00;
    zb = eb == 8'h00;
    na = ea == 8'hff && a[6:0] != 7'h0;
    nb = eb == 8'hff && b[6:0] != 7'h0;
    ia = ea == 8'hff && a[6:0] == 7'h0;
    ib = eb == 8'hff && b[6:0] == 7'h0;
    swp = {eb, b[6:0]} > {ea, a[6:0]};
    sx = swp ? b[15] : a[15];
    sy2 = swp ? a[15] : b[15];
    ex = swp ? eb : ea;
    ey = swp ? ea : eb;
    fx = swp ? b[6:0] : a[6:0];
    fy = swp ? a[6:0] : b[6:0];
    sub = sx ^ sy2;
    d = ex - ey;
    big = {2'b01, fx, 10'h000};
    wide = {2'b01, fy, 29'h0} >> d;
    st = (|wide[18:0]) | (d >= 8'd38);
    sml = wide[37:19] | {18'h0, st};
    sum = sub ? big - sml : big + sml;
    p = 5'd0;
    for (int i = 0; i < 19; i++)
      if (sum[i]) p = 5'(i);
    // a carry out keeps the dropped bit as sticky
    if (sum[18])
      norm = {1'b0, sum[18:1]} | {18'h0, sum[0]};
    else
      norm = sum << (5'd17 - p);
    m = norm[17:10];
    g = norm[9];
    rup = g & ((|norm[8:0]) | m[0]);
    r = {1'b0, m} + {8'h00, rup};
    e = $signed({3'b000, ex}) + $signed({6'h00, p})
      - 11'sd17 + $signed({10'h000, r[8]});
    if (na | nb | (ia & ib & (a[15] ^ b[15])))
      y = 16'h7fc0;
    else if (ia)
      y = a;
    else if (ib)
      y = b;
    else if (za & zb)
      y = {a[15] & b[15], 15'h0000};
    else if (za)
      y = b;
    else if (zb)
      y = a;
    else if (sum == 19'h0)
      y = 16'h0000;
    else if (e >= 11'sd255)
      y = {sx, 8'hff, 7'h00};
    else if (e <= 11'sd0)
      y = {sx, 15'h0000};
    else
      y = {sx, e[7:0], r[6:0]};
  end

  assign unused = ^{r[7], norm[18]};
endmodule

module b16fp_vmac #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [16*LANES-1:0]   oprA,
  input  logic [16*LANES-1:0]   oprB,
  output logic                  out_valid,
  output logic [15:0]           out_result,
  output logic [CNT_W-1:0]      out_count,
  output logic                  busy
);
  localparam int NL = $clog2(LANES);
  localparam int NN = 2 * LANES - 1;

  // node[] holds every tree level back to back: products, then halves
  logic [NN-1:0][15:0] node, nxt;
  logic [NL:0] pv, pf, pl;
  logic [15:0] acc, acc_sum, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic fopen, a_v, a_f, a_l;

  for (genvar k = 0; k < LANES; k++) begin : g_mul
    b16fpmul u_mul (
      .a (oprA[16*k +: 16]),
      .b (oprB[16*k +: 16]),
      .y (nxt[k])
    );
  end

  for (genvar lv = 1; lv <= NL; lv++) begin : g_lvl
    localparam int BI = 2 * LANES - 2 * (LANES >> (lv - 1));
    localparam int BO = 2 * LANES - 2 * (LANES >> lv);
    for (genvar j = 0; j < (LANES >> lv); j++) begin : g_add
      b16fpadd u_add (
        .a (node[BI + 2*j]),
        .b (node[BI + 2*j + 1]),
        .y (nxt[BO + j])
      );
    end
  end

  assign a_v = pv[NL];
  assign a_f = pf[NL];
  assign a_l = pl[NL];

  b16fpadd u_acc (
    .a (acc),
    .b (node[NN-1]),
    .y (acc_sum)
  );

  always_comb begin
    acc_nxt = a_f ? node[NN-1] : acc_sum;
    if (a_f)
      cnt_nxt = CNT_W'(1);
    else if (&cnt)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node <= '0;
      pv <= '0;
      pf <= '0;
      pl <= '0;
    end else begin
      node <= nxt;
      pv[0] <= in_valid;
      pf[0] <= in_valid & in_first;
      pl[0] <= in_valid & in_last;
      for (int i = 1; i <= NL; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 16'h0000;
      cnt <= '0;
      out_valid <= 1'b0;
      out_result <= 16'h0000;
      out_count <= '0;
    end else begin
      out_valid <= a_v & a_l;
      if (a_v) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end
      if (a_v & a_l) begin
        out_result <= acc_nxt;
        out_count <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fopen <= 1'b0;
    else if (in_valid & in_last)
      fopen <= 1'b0;
    else if (in_valid & in_first)
      fopen <= 1'b1;
  end

  assign busy = (|pv) | fopen;
endmodule

// File: tb/tb_b16fp_vmac.sv
// Randomised scoreboard bench for b16fp_vmac against a real-arithmetic
// bfloat16 model (FTZ, round-to-nearest-even).

module tb_b16fp_vmac;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic v4, f4, l4, ov4, busy4;
  logic [63:0] a4, b4;
  logic [15:0] res4;
  logic [CW-1:0] cnt4;

  logic vs, fs, ls, ov1, ov16, busy1, busy16;
  logic [15:0] a1, b1, res1, res16, cnt1, cnt16;
  logic [255:0] a16, b16;

  typedef struct {
    logic [15:0] res;
    int cnt;
    int cyc;
  } exp_t;
  exp_t q[$];

  logic [15:0] macc;
  int mcnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  b16fp_vmac #(.LANES(4), .CNT_W(CW)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_first(f4),
    .in_last(l4), .oprA(a4), .oprB(b4), .out_valid(ov4),
    .out_result(res4), .out_count(cnt4), .busy(busy4)
  );

  b16fp_vmac #(.LANES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_first(fs),
    .in_last(ls), .oprA(a1), .oprB(b1), .out_valid(ov1),
    .out_result(res1), .out_count(cnt1), .busy(busy1)
  );

  b16fp_vmac #(.LANES(16), .CNT_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_first(fs),
    .in_last(ls), .oprA(a16), .oprB(b16), .out_valid(ov16),
    .out_result(res16), .out_count(cnt16), .busy(busy16)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic real to_real(input logic [15:0] h);
    logic [63:0] bits;
    if (h[14:7] == 8'h00)
      bits = {h[15], 63'h0};
    else if (h[14:7] == 8'hff)
      bits = {h[15], 11'h7ff, (h[6:0] != 7'h0), 51'h0};
    else
      bits = {h[15], 11'(int'(h[14:7]) - 127 + 1023), h[6:0], 45'h0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] from_real(input real x);
    logic [63:0] bits;
    logic [44:0] rem, half;
    int ex, m, e;
    bits = $realtobits(x);
    ex = int'(bits[62:52]);
    if (ex == 2047)
      return (bits[51:0] != 52'h0) ? 16'h7fc0 : {bits[63], 8'hff, 7'h0};
    if (ex == 0)
      return {bits[63], 15'h0};
    m = int'({1'b1, bits[51:45]});
    rem = bits[44:0];
    half = {1'b1, 44'h0};
    if (rem > half || (rem == half && (m % 2) == 1))
      m++;
    e = ex - 1023 + 127;
    if (m == 256) begin
      m = 128;
      e++;
    end
    if (e >= 255)
      return {bits[63], 8'hff, 7'h0};
    if (e <= 0)
      return {bits[63], 15'h0};
    return {bits[63], 8'(e), 7'(m)};
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] x, y);
    return from_real(to_real(x) * to_real(y));
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] x, y);
    return from_real(to_real(x) + to_real(y));
  endfunction

  function automatic logic [15:0] tree4(input logic [63:0] a,
                                        input logic [63:0] b);
    logic [15:0] t[4];
    for (int i = 0; i < 4; i++)
      t[i] = fmul(a[16*i +: 16], b[16*i +: 16]);
    for (int w = 4; w > 1; w = w / 2)
      for (int j = 0; j < w / 2; j++)
        t[j] = fadd(t[2*j], t[2*j+1]);
    return t[0];
  endfunction

  function automatic logic [15:0] rand_bf();
    logic [15:0] sp[6];
    sp = '{16'h0000, 16'h8000, 16'h7f80, 16'hff80, 16'h7fc1, 16'h0001};
    if ($urandom % 64 == 0)
      return sp[$urandom % 6];
    return {1'($urandom), 8'(120 + $urandom % 15), 7'($urandom)};
  endfunction

  function automatic logic [63:0] rand_vec();
    return {rand_bf(), rand_bf(), rand_bf(), rand_bf()};
  endfunction

  task automatic beat(input logic v, f, l, input logic [63:0] a, b);
    logic [15:0] t;
    @(negedge clk);
    v4 = v;
    f4 = f;
    l4 = l;
    a4 = a;
    b4 = b;
    if (v) begin
      t = tree4(a, b);
      if (f) begin
        macc = t;
        mcnt = 1;
      end else begin
        macc = fadd(macc, t);
        mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
      end
      if (l)
        q.push_back('{macc, mcnt, cyc + 4});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v4 = 1'b0;
      f4 = 1'($urandom);
      l4 = 1'($urandom);
      a4 = rand_vec();
      b4 = rand_vec();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov4 === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: result %h count %0d at cycle %0d",
                   res4, cnt4, cyc);
        end else begin
          e = q.pop_front();
          chk("result", 32'(res4), 32'(e.res));
          chk("count", 32'(cnt4), 32'(e.cnt));
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  localparam logic [63:0] ONES = {4{16'h3f80}};
  localparam logic [63:0] SEQ = {16'h4080, 16'h4040, 16'h4000, 16'h3f80};

  initial begin : stim
    int c, lat1, lat16, len;
    logic [15:0] r1, r16;
    logic [15:0] n1, n16;
    rst_n = 1'b0;
    v4 = 1'b0; f4 = 1'b0; l4 = 1'b0; a4 = '0; b4 = '0;
    vs = 1'b0; fs = 1'b0; ls = 1'b0;
    a1 = '0; b1 = '0; a16 = '0; b16 = '0;
    macc = 16'h0000;
    mcnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(ov4), 0);
    chk("rst_out_result", 32'(res4), 0);
    chk("rst_out_count", 32'(cnt4), 0);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_l16_valid", 32'(ov16), 0);
    rst_n = 1'b1;

    beat(1, 1, 1, SEQ, ONES);
    idle(6);
    beat(1, 1, 0, ONES, ONES);
    beat(1, 0, 1, ONES, ONES);
    idle(6);

    beat(1, 1, 0, ONES, ONES);
    repeat (3) begin
      idle(1);
      chk("busy_gap", 32'(busy4), 1);
    end
    beat(1, 0, 1, ONES, ONES);
    idle(3);
    chk("busy_inflight", 32'(busy4), 1);
    idle(3);
    chk("busy_idle", 32'(busy4), 0);

    beat(1, 1, 1, SEQ, ONES);
    beat(1, 1, 1, {4{16'h3f00}}, {4{16'h4000}});
    idle(6);

    beat(1, 1, 0, rand_vec(), rand_vec());
    beat(1, 1, 1, ONES, ONES);
    beat(1, 0, 1, ONES, ONES);
    idle(6);

    beat(1, 1, 0, ONES, {4{16'h3f00}});
    repeat (18) beat(1, 0, 0, ONES, {4{16'h3f00}});
    beat(1, 0, 1, ONES, {4{16'h3f00}});
    idle(6);

    for (int fr = 0; fr < 40; fr++) begin
      if ($urandom % 8 == 0)
        beat(1, 1, 0, rand_vec(), rand_vec());
      len = 1 + int'($urandom % 5);
      for (int i = 0; i < len; i++) begin
        beat(1, (i == 0) && ($urandom % 8 != 0), i == len - 1,
             rand_vec(), rand_vec());
        idle(int'($urandom % 3));
      end
    end
    idle(8);

    beat(1, 1, 0, rand_vec(), rand_vec());
    beat(1, 0, 0, rand_vec(), rand_vec());
    @(negedge clk);
    v4 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov4), 0);
    chk("midrst_result", 32'(res4), 0);
    chk("midrst_count", 32'(cnt4), 0);
    chk("midrst_busy", 32'(busy4), 0);
    macc = 16'h0000;
    mcnt = 0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    beat(1, 0, 1, SEQ, ONES);
    idle(6);

    @(negedge clk);
    vs = 1'b1; fs = 1'b1; ls = 1'b1;
    a1 = 16'h3f80; b1 = 16'h3f80;
    a16 = {16{16'h3f80}}; b16 = {16{16'h3f80}};
    c = cyc;
    lat1 = -1; lat16 = -1;
    r1 = '0; r16 = '0; n1 = '0; n16 = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vs = 1'b0; fs = 1'b0; ls = 1'b0;
      if (ov1 === 1'b1 && lat1 < 0) begin
        lat1 = cyc - c; r1 = res1; n1 = cnt1;
      end
      if (ov16 === 1'b1 && lat16 < 0) begin
        lat16 = cyc - c; r16 = res16; n16 = cnt16;
      end
    end
    chk("l1_latency", 32'(lat1), 2);
    chk("l1_result", 32'(r1), 32'h3f80);
    chk("l1_count", 32'(n1), 1);
    chk("l16_latency", 32'(lat16), 6);
    chk("l16_result", 32'(r16), 32'h4180);
    chk("l16_count", 32'(n16), 1);
    chk("l16_busy_end", 32'(busy16), 0);

    idle(10);
    chk("drain", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
